// File: rtl/median_window_ctrl.sv
// Frame/line sequencer for the 5x5 binary median filter: line-buffer clear, shift enable, window-valid tagging.
// Build option MEDIAN_CTRL_FRAME_CNT_EN adds a 16-bit count of completed frames (frame_cnt).
module median_window_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int WIN        = 5,
    parameter int CLR_CYCLES = 640,
    parameter int PIPE_LAT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        VGA_BLANK_N,
    input  logic        VGA_VS,
    input  logic        err_clr,
    output logic        buf_shift_en,
    output logic        ram_clr,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        win_valid,
    output logic        frame_done,
    output logic        busy,
    output logic [2:0]  err
`ifdef MEDIAN_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam logic [9:0]  H_MAX    = 10'(H_ACTIVE);
    localparam logic [9:0]  Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  EDGE     = 10'(WIN - 1);
    localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_VS   = 3'd1,
        S_CLEAR     = 3'd2,
        S_WAIT_LINE = 3'd3,
        S_ACTIVE    = 3'd4,
        S_FRAME_END = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        blank_q, blank_d;
    logic        vs_q, vs_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [15:0] clr_cnt_q, clr_cnt_d;
    logic        skip_q, skip_d;
    logic        shift_q, shift_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic        win_raw_q, win_raw_d;
    logic        ram_clr_q, ram_clr_d;
    logic        frame_done_q, frame_done_d;
    logic        busy_q, busy_d;
    logic [2:0]  err_q, err_d;
    logic [PIPE_LAT-1:0] win_pipe_q, win_pipe_d;

    logic        vs_fall, blank_rise, blank_fall;
    logic        pixel_req;
    logic [9:0]  cur_x;
    logic [2:0]  err_set;

    assign vs_fall    = vs_q & ~VGA_VS;
    assign blank_rise = ~blank_q & VGA_BLANK_N;
    assign blank_fall = blank_q & ~VGA_BLANK_N;

    always_comb begin
        state_d   = state_q;
        blank_d   = VGA_BLANK_N;
        vs_d      = VGA_VS;
        x_d       = x_q;
        y_d       = y_q;
        clr_cnt_d = clr_cnt_q;
        skip_d    = skip_q;
        shift_d   = 1'b0;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        win_raw_d = 1'b0;
        pixel_req = 1'b0;
        cur_x     = x_q;
        err_set   = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (vs_fall) begin
                    state_d   = S_CLEAR;
                    y_d       = 10'd0;
                    clr_cnt_d = 16'd0;
                    skip_d    = 1'b0;
                end
            end
            S_CLEAR: begin
                // Video during the sweep means the clear raced the frame: finish it, then resync.
                if (VGA_BLANK_N) begin
                    err_set[2] = 1'b1;
                    skip_d     = 1'b1;
                end
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = (skip_q || VGA_BLANK_N) ? S_WAIT_VS : S_WAIT_LINE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 16'd1;
                end
            end
            S_WAIT_LINE: begin
                if (vs_fall) begin
                    err_set[2] = 1'b1;
                    state_d    = S_CLEAR;
                    y_d        = 10'd0;
                    clr_cnt_d  = 16'd0;
                    skip_d     = 1'b0;
                end else if (blank_rise) begin
                    // The rising-edge cycle already carries pixel 0.
                    state_d   = S_ACTIVE;
                    pixel_req = 1'b1;
                    cur_x     = 10'd0;
                end
            end
            S_ACTIVE: begin
                if (vs_fall) begin
                    err_set[2] = 1'b1;
                    state_d    = S_CLEAR;
                    y_d        = 10'd0;
                    clr_cnt_d  = 16'd0;
                    skip_d     = 1'b0;
                end else if (blank_fall) begin
                    if (x_q < H_MAX) err_set[1] = 1'b1;
                    if (y_q == Y_LAST) begin
                        state_d = S_FRAME_END;
                    end else begin
                        y_d     = y_q + 10'd1;
                        state_d = S_WAIT_LINE;
                    end
                end else if (VGA_BLANK_N) begin
                    pixel_req = 1'b1;
                end
            end
            S_FRAME_END: begin
                state_d = enable ? S_WAIT_VS : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pixel_req) begin
            if (cur_x < H_MAX) begin
                shift_d   = 1'b1;
                pix_x_d   = cur_x;
                pix_y_d   = y_q;
                x_d       = cur_x + 10'd1;
                win_raw_d = (cur_x >= EDGE) && (y_q >= EDGE);
            end else begin
                err_set[0] = 1'b1;
            end
        end

        ram_clr_d    = (state_d == S_CLEAR);
        frame_done_d = (state_d == S_FRAME_END);
        busy_d       = (state_d != S_IDLE);
        err_d        = (err_clr ? 3'b000 : err_q) | err_set;
    end

    // Valid tags ride alongside the filter pipeline; a buffer clear flushes them.
    always_comb begin
        win_pipe_d = '0;
        if (!ram_clr_q) begin
            win_pipe_d[0] = win_raw_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                win_pipe_d[i] = win_pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            blank_q      <= 1'b0;
            vs_q         <= 1'b0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            clr_cnt_q    <= 16'd0;
            skip_q       <= 1'b0;
            shift_q      <= 1'b0;
            pix_x_q      <= 10'd0;
            pix_y_q      <= 10'd0;
            win_raw_q    <= 1'b0;
            ram_clr_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 3'b000;
            win_pipe_q   <= '0;
        end else begin
            state_q      <= state_d;
            blank_q      <= blank_d;
            vs_q         <= vs_d;
            x_q          <= x_d;
            y_q          <= y_d;
            clr_cnt_q    <= clr_cnt_d;
            skip_q       <= skip_d;
            shift_q      <= shift_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            win_raw_q    <= win_raw_d;
            ram_clr_q    <= ram_clr_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            win_pipe_q   <= win_pipe_d;
        end
    end

`ifdef MEDIAN_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_done_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) frame_cnt_q <= 16'd0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign buf_shift_en = shift_q;
    assign ram_clr      = ram_clr_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign win_valid    = win_pipe_q[PIPE_LAT-1];
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule
